// File: rtl/rns_serial_modadd_ctrl.sv
// Bit-serial modular adder: (a + b) mod m using one shared 1-bit full adder.
// An ADD pass forms the W+1-bit sum c_add:s_r, a SUB pass forms s_r - m_r,
// and the carry-out of both passes selects the reduced or unreduced sum.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; operands latched on accept
// ADD    | W cycles, LSB first: s_r = a_r + b_r, carry-out kept in c_add
// SUB    | W cycles, LSB first: d_r = s_r + ~m_r + 1, result selected at end
// DONE   | one-cycle done pulse, result valid and held
module rns_serial_modadd_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [CW-1:0]  r_cnt;
  logic           r_carry;
  logic           r_c_add;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_m;
  logic [W-1:0]   r_s;
  logic [W-1:0]   r_d;
  logic [W-1:0]   r_result;

  logic           w_x;
  logic           w_y;
  logic           w_c;
  logic           w_sum;
  logic           w_cout;
  logic           w_last;
  logic [W-1:0]   w_d_final;

  assign w_last    = (r_cnt == CW'(W - 1));

  // The single full-adder cell shared by both passes.
  assign w_sum     = w_x ^ w_y ^ w_c;
  assign w_cout    = (w_x & w_y) | ((w_x ^ w_y) & w_c);

  // Difference register including the bit produced this cycle.
  assign w_d_final = {w_sum, r_d[W-1:1]};

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;

  // Full-adder operand steering: addends in ADD, s_r and ~m_r in SUB.
  always_comb begin
    w_x = 1'b0;
    w_y = 1'b0;
    w_c = 1'b0;
    case (r_state)
      S_ADD: begin
        w_x = r_a[r_cnt];
        w_y = r_b[r_cnt];
        w_c = r_carry;
      end
      S_SUB: begin
        w_x = r_s[r_cnt];
        w_y = ~r_m[r_cnt];
        w_c = r_carry;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_ADD;
      S_ADD:  if (w_last) w_next_state = S_SUB;
      S_SUB:  if (w_last) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: operand capture, serial shifting, carry chain and result select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_c_add  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_s      <= '0;
      r_d      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_m     <= m;
            r_carry <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_ADD: begin
          r_s <= {w_sum, r_s[W-1:1]};
          if (w_last) begin
            r_c_add <= w_cout;
            r_carry <= 1'b1;  // +1 of the two's-complement subtraction
            r_cnt   <= '0;
          end else begin
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_SUB: begin
          r_d     <= w_d_final;
          r_carry <= w_cout;
          if (w_last) begin
            r_cnt    <= '0;
            // Sum >= m when either pass carried out of the W-bit field.
            r_result <= (r_c_add | w_cout) ? w_d_final : r_s;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_serial_modadd_ctrl.sv
// Scoreboard bench for rns_serial_modadd_ctrl with W = 8.
module tb_rns_serial_modadd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] m;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];

  rns_serial_modadd_ctrl #(.W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .m      (m),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y, input logic [7:0] mm);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, mm}) s = s - {1'b0, mm};
    return s[7:0];
  endfunction

  // One operation: accept, then expect done at the 16th edge after accept.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] tm, input string name);
    int done_k;
    int busy_cnt;
    logic [7:0] expv;
    @(negedge clk);
    a = ta; b = tb_v; m = tm; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); m = 8'($urandom);
    exp_q.push_back(model(ta, tb_v, tm));
    busy_cnt = busy ? 1 : 0;
    done_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_k = k;
        break;
      end
    end
    tests_run++;
    if (done_k != 16) begin
      tests_failed++;
      $display("FAIL %s latency: done seen at edge %0d after accept, required 17 (-1+1 = timeout)", name, done_k + 1);
    end
    tests_run++;
    if (busy_cnt != 17) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: got %0d, required 17", name, busy_cnt);
    end
    expv = exp_q.pop_front();
    tests_run++;
    if (result !== expv) begin
      tests_failed++;
      $display("FAIL %s result: a=%0d b=%0d m=%0d got %0d, required %0d", name, ta, tb_v, tm, result, expv);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== expv) begin
      tests_failed++;
      $display("FAIL %s after_done: done=%b busy=%b result=%0d, required 0 0 %0d", name, done, busy, result, expv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b result=%0d, required 0 0 0", busy, done, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    do_op(8'd10, 8'd20, 8'd251, "basic");
    do_op(8'd200, 8'd100, 8'd251, "wrap");
  endtask

  task automatic test_boundaries();
    do_op(8'd250, 8'd250, 8'd251, "carry_out");
    do_op(8'd125, 8'd126, 8'd251, "equal");
    do_op(8'd255, 8'd255, 8'd3, "out_of_range");
    do_op(8'd5, 8'd0, 8'd0, "m_zero");
    do_op(8'd1, 8'd0, 8'd2, "m_two");
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa[3];
    logic [7:0] ob[3];
    logic [7:0] expv;
    oa = '{8'd17, 8'd240, 8'd99};
    ob = '{8'd33, 8'd200, 8'd100};
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e < 54; e++) begin
      if (e % 18 == 0) begin
        a = oa[e / 18]; b = ob[e / 18]; m = 8'd251;
        exp_q.push_back(model(oa[e / 18], ob[e / 18], 8'd251));
      end else begin
        a = 8'($urandom); b = 8'($urandom); m = 8'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      if (e % 18 == 16) begin
        tests_run++;
        if (done !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_done op%0d: done=%b, required 1", e / 18, done);
        end
        expv = exp_q.pop_front();
        tests_run++;
        if (result !== expv) begin
          tests_failed++;
          $display("FAIL b2b_result op%0d: got %0d, required %0d", e / 18, result, expv);
        end
      end else if (e % 18 == 17) begin
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_gap op%0d: busy=%b done=%b, required 0 0", e / 18, busy, done);
        end
      end else if (done) begin
        tests_run++;
        tests_failed++;
        $display("FAIL b2b_spurious_done at edge %0d: done=1, required 0", e);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_midop();
    int spurious;
    @(negedge clk);
    a = 8'd100; b = 8'd100; m = 8'd251; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'd0) begin
      tests_failed++;
      $display("FAIL midop_reset: busy=%b done=%b result=%0d, required 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    tests_run++;
    if (spurious != 0) begin
      tests_failed++;
      $display("FAIL midop_no_done: %0d busy/done cycles after abort, required 0", spurious);
    end
    do_op(8'd3, 8'd6, 8'd7, "after_abort");
  endtask

  task automatic test_random();
    logic [7:0] tm;
    logic [7:0] ta;
    logic [7:0] tb_v;
    for (int i = 0; i < 1000; i++) begin
      tm   = 8'($urandom_range(255, 2));
      ta   = 8'($urandom_range(32'(tm) - 1, 0));
      tb_v = 8'($urandom_range(32'(tm) - 1, 0));
      do_op(ta, tb_v, tm, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
